seq_stage_ctrl: RTL and testbench



---
 rtl/seq_stage_ctrl_if.sv | 37 +++
 rtl/seq_stage_ctrl.sv | 156 +++++++++++++++
 tb/tb_seq_stage_ctrl.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/seq_stage_ctrl_if.sv
// Handshake bundle between the SEQ stage sequencer and its datapath blocks.
// master = sequencer side, slave = datapath/memory side.
interface seq_stage_ctrl_if;
   logic        start;
   logic        step;
   logic [3:0]  icode;
   logic        f_halt;
   logic        f_i_error;
   logic        f_mem_error;
   logic        cnd;
   logic [63:0] valC;
   logic [63:0] valP;
   logic [63:0] valM;
   logic        dmem_ready;
   logic        dmem_error;
   logic [63:0] pc;
   logic        fetch_en;
   logic        decode_en;
   logic        exec_en;
   logic        mem_en;
   logic        wb_en;
   logic [2:0]  stat;
   logic        busy;
   logic [31:0] retired;

   modport master (
      input  start, step, icode, f_halt, f_i_error, f_mem_error, cnd,
             valC, valP, valM, dmem_ready, dmem_error,
      output pc, fetch_en, decode_en, exec_en, mem_en, wb_en, stat, busy, retired
   );

   modport slave (
      output start, step, icode, f_halt, f_i_error, f_mem_error, cnd,
             valC, valP, valM, dmem_ready, dmem_error,
      input  pc, fetch_en, decode_en, exec_en, mem_en, wb_en, stat, busy, retired
   );
endinterface

// File: rtl/seq_stage_ctrl.sv
// Y86-64 SEQ multi-cycle sequencer: owns the PC, steps stage enables, maps faults to stat.
// Optional macro SEQ_STEP_EN adds a STEP_WAIT state for single-step operation.
module seq_stage_ctrl #(
   parameter logic [63:0] RESET_PC    = 64'd0,
   parameter int unsigned MEM_TIMEOUT = 16
) (
   input logic              clk,
   input logic              rst_n,
   seq_stage_ctrl_if.master bus
);

   localparam int unsigned CntW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(MEM_TIMEOUT - 1);

   localparam logic [2:0] StatAok = 3'd1;
   localparam logic [2:0] StatHlt = 3'd2;
   localparam logic [2:0] StatAdr = 3'd3;
   localparam logic [2:0] StatIns = 3'd4;

   typedef enum logic [3:0] {
      StIdle, StFetch, StDecode, StExecute, StMemory, StWrback, StPcupd, StHalted
`ifdef SEQ_STEP_EN
      , StStepWait
`endif
   } state_e;

   state_e          state_q, state_d;
   logic [63:0]     pc_q, pc_d;
   logic [2:0]      stat_q, stat_d;
   logic [31:0]     retired_q, retired_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [4:0]      en_q, en_d;
   logic            busy_q, busy_d;

`ifndef SEQ_STEP_EN
   logic unused_step;
   assign unused_step = bus.step;
`endif

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      stat_d    = stat_q;
      retired_d = retired_q;
      cnt_d     = cnt_q;
      case (state_q)
         StIdle, StHalted: begin
            if (bus.start) begin
               state_d   = StFetch;
               pc_d      = RESET_PC;
               stat_d    = StatAok;
               retired_d = '0;
            end
         end
         StFetch:   state_d = StDecode;
         // Fault leaves pc on the offending instruction.
         StDecode: begin
            if (bus.f_mem_error) begin
               stat_d  = StatAdr;
               state_d = StHalted;
            end else if (bus.f_i_error) begin
               stat_d  = StatIns;
               state_d = StHalted;
            end else if (bus.f_halt) begin
               stat_d  = StatHlt;
               state_d = StHalted;
            end else begin
               state_d = StExecute;
            end
         end
         StExecute: state_d = StMemory;
         StMemory: begin
            if (bus.dmem_ready) begin
               cnt_d   = '0;
               state_d = bus.dmem_error ? StHalted : StWrback;
               if (bus.dmem_error) stat_d = StatAdr;
            end else if (cnt_q == CntLast) begin
               cnt_d   = '0;
               stat_d  = StatAdr;
               state_d = StHalted;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StWrback:  state_d = StPcupd;
         StPcupd: begin
            if (bus.icode == 4'h8 || (bus.icode == 4'h7 && bus.cnd)) begin
               pc_d = bus.valC;
            end else if (bus.icode == 4'h9) begin
               pc_d = bus.valM;
            end else begin
               pc_d = bus.valP;
            end
            retired_d = retired_q + 32'd1;
`ifdef SEQ_STEP_EN
            state_d = StStepWait;
`else
            state_d = StFetch;
`endif
         end
`ifdef SEQ_STEP_EN
         StStepWait: if (bus.step) state_d = StFetch;
`endif
         default:   state_d = StIdle;
      endcase
   end

   // Enables and busy are decoded from the next state so they register in step with it.
   always_comb begin
      en_d   = '0;
      busy_d = 1'b1;
      case (state_d)
         StFetch:   en_d = 5'b00001;
         StDecode:  en_d = 5'b00010;
         StExecute: en_d = 5'b00100;
         StMemory:  en_d = 5'b01000;
         StWrback:  en_d = 5'b10000;
         StIdle, StHalted: busy_d = 1'b0;
`ifdef SEQ_STEP_EN
         StStepWait: busy_d = 1'b0;
`endif
         default:   en_d = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         pc_q      <= RESET_PC;
         stat_q    <= StatAok;
         retired_q <= '0;
         cnt_q     <= '0;
         en_q      <= '0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         stat_q    <= stat_d;
         retired_q <= retired_d;
         cnt_q     <= cnt_d;
         en_q      <= en_d;
         busy_q    <= busy_d;
      end
   end

   assign bus.pc        = pc_q;
   assign bus.stat      = stat_q;
   assign bus.retired   = retired_q;
   assign bus.busy      = busy_q;
   assign bus.fetch_en  = en_q[0];
   assign bus.decode_en = en_q[1];
   assign bus.exec_en   = en_q[2];
   assign bus.mem_en    = en_q[3];
   assign bus.wb_en     = en_q[4];

endmodule

// File: tb/tb_seq_stage_ctrl.sv
// Self-checking bench for seq_stage_ctrl: directed program plus random instructions
// checked against an instruction-level model of PC, stat, retired count and cycle cost.
module tb_seq_stage_ctrl;
   localparam int unsigned MemTimeout = 16;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   seq_stage_ctrl_if bus();

   seq_stage_ctrl #(.RESET_PC(64'd0), .MEM_TIMEOUT(MemTimeout)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   logic [63:0] exp_pc = 64'd0;
   logic [2:0]  exp_stat = 3'd1;
   logic [31:0] exp_ret = 32'd0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] next_pc(input logic [3:0] ic, input logic c,
                                           input logic [63:0] vc, vp, vm);
      if (ic == 4'h8 || (ic == 4'h7 && c)) return vc;
      if (ic == 4'h9) return vm;
      return vp;
   endfunction

   task automatic chk_reset(input string tag);
      chk({tag, "_pc"}, bus.pc, 64'd0);
      chk({tag, "_stat"}, bus.stat, 3'd1);
      chk({tag, "_busy"}, bus.busy, 1'b0);
      chk({tag, "_retired"}, bus.retired, 32'd0);
      chk({tag, "_en"}, {bus.fetch_en, bus.decode_en, bus.exec_en, bus.mem_en, bus.wb_en}, 5'd0);
   endtask

   task automatic do_start();
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      exp_pc = 64'd0;
      exp_stat = 3'd1;
      exp_ret = 32'd0;
      chk("start_fetch_en", bus.fetch_en, 1'b1);
      chk("start_stat", bus.stat, exp_stat);
      chk("start_retired", bus.retired, exp_ret);
   endtask

   // Runs one instruction starting from a FETCH cycle; ff = {mem_error, i_error, halt}.
   task automatic do_instr(input logic [3:0] ic, input logic c, input logic [63:0] vc, vp, vm,
                           input int waits, input logic derr, input logic [2:0] ff);
      int n = 0;
      int mem_cycles = 0;
      int exp_n;
      bit wb_seen = 0;
      bit multi = 0;
      bit halts = 0;
      bit expired = 1;
      chk("entry_fetch_en", bus.fetch_en, 1'b1);
      chk("entry_pc", bus.pc, exp_pc);
      bus.icode = ic; bus.cnd = c; bus.valC = vc; bus.valP = vp; bus.valM = vm;
      bus.f_halt = ff[0]; bus.f_i_error = ff[1]; bus.f_mem_error = ff[2];
      bus.dmem_error = derr; bus.dmem_ready = 1'b0;
      for (int i = 0; i < 60; i++) begin
         tick();
         n++;
         if (bus.wb_en) wb_seen = 1;
         if ($countones({bus.fetch_en, bus.decode_en, bus.exec_en, bus.mem_en, bus.wb_en}) > 1)
            multi = 1;
         if (bus.fetch_en || !bus.busy) begin
            expired = 0;
            break;
         end
         if (bus.mem_en) begin
            bus.dmem_ready = (mem_cycles >= waits);
            mem_cycles++;
         end else begin
            bus.dmem_ready = 1'b0;
         end
         bus.start = 1'($urandom % 2);
         bus.step  = 1'($urandom % 2);
      end
      bus.start = 1'b0; bus.step = 1'b0; bus.dmem_ready = 1'b0;

      if (ff != 3'd0) begin
         exp_n = 2; halts = 1;
         exp_stat = ff[2] ? 3'd3 : (ff[1] ? 3'd4 : 3'd2);
      end else if (waits >= int'(MemTimeout)) begin
         exp_n = 3 + MemTimeout; halts = 1; exp_stat = 3'd3;
      end else if (derr) begin
         exp_n = 4 + waits; halts = 1; exp_stat = 3'd3;
      end else begin
         exp_n = 6 + waits;
         exp_pc = next_pc(ic, c, vc, vp, vm);
         exp_ret = exp_ret + 32'd1;
      end
      chk("cycle_budget_expired", expired, 1'b0);
      chk("cycles", n, exp_n);
      chk("onehot", multi, 1'b0);
      chk("wb_seen", wb_seen, !halts);
      chk("retired", bus.retired, exp_ret);
      chk("pc", bus.pc, exp_pc);
      chk("stat", bus.stat, exp_stat);
      if (halts) begin
         chk("halt_busy", bus.busy, 1'b0);
         chk("halt_fetch_en", bus.fetch_en, 1'b0);
      end else begin
`ifdef SEQ_STEP_EN
         for (int k = 0; k < 5; k++) begin
            chk("stepwait_busy", bus.busy, 1'b0);
            chk("stepwait_fetch_en", bus.fetch_en, 1'b0);
            bus.start = 1'b1;
            tick();
         end
         bus.start = 1'b0;
         bus.step = 1'b1;
         tick();
         bus.step = 1'b0;
         chk("step_pc", bus.pc, exp_pc);
`endif
         chk("next_fetch_en", bus.fetch_en, 1'b1);
      end
   endtask

   initial begin
      bus.start = 0; bus.step = 0; bus.icode = 0; bus.cnd = 0;
      bus.f_halt = 0; bus.f_i_error = 0; bus.f_mem_error = 0;
      bus.valC = 0; bus.valP = 0; bus.valM = 0; bus.dmem_ready = 0; bus.dmem_error = 0;
      tick(); tick();
      chk_reset("reset");
      rst_n = 1'b1;
      tick(); tick(); tick();
      chk("idle_busy", bus.busy, 1'b0);
      chk("idle_fetch_en", bus.fetch_en, 1'b0);

      // irmovq at 0 then halt at 10
      do_start();
      do_instr(4'h3, 0, 64'd0, 64'd10, 64'd0, 0, 0, 3'b000);
      do_instr(4'h0, 0, 64'd0, 64'd11, 64'd0, 0, 0, 3'b001);

      // jumps, call, ret
      do_start();
      do_instr(4'h7, 1, 64'h1E, 64'd9, 64'd0, 0, 0, 3'b000);
      do_instr(4'h7, 0, 64'h77, 64'd9, 64'd0, 0, 0, 3'b000);
      do_instr(4'h8, 0, 64'h28, 64'h12, 64'd0, 0, 0, 3'b000);
      do_instr(4'h9, 0, 64'h55, 64'h29, 64'h1D, 0, 0, 3'b000);

      for (int r = 0; r < 24; r++) begin
         do_instr(4'($urandom_range(11, 0)), 1'($urandom % 2),
                  {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
                  int'($urandom_range(4, 0)), 0, 3'b000);
      end

      // Illegal instruction at 0x40
      do_instr(4'h7, 1, 64'h40, 64'd3, 64'd0, 1, 0, 3'b000);
      do_instr(4'hF, 0, 64'd0, 64'h41, 64'd0, 0, 0, 3'b010);

      // Flag priority, wait states, data fault, timeout
      do_start();
      do_instr(4'h3, 0, 64'd0, 64'd10, 64'd0, 3, 0, 3'b000);
      do_instr(4'h3, 0, 64'd0, 64'd20, 64'd0, 0, 0, 3'b111);
      do_start();
      do_instr(4'h5, 0, 64'd0, 64'd10, 64'd0, 1, 1, 3'b000);
      do_start();
      do_instr(4'h4, 0, 64'd0, 64'd10, 64'd0, 15, 0, 3'b000);
      do_instr(4'h5, 0, 64'd0, 64'd20, 64'd0, 100, 0, 3'b000);

      // Reset in the middle of a memory wait
      do_start();
      bus.icode = 4'h5; bus.f_halt = 0; bus.f_i_error = 0; bus.f_mem_error = 0;
      bus.dmem_ready = 0;
      for (int k = 0; k < 5; k++) tick();
      chk("midwait_mem_en", bus.mem_en, 1'b1);
      rst_n = 1'b0;
      tick();
      chk_reset("midwait_reset");
      rst_n = 1'b1;
      tick();
      chk("post_reset_busy", bus.busy, 1'b0);
      do_start();
      do_instr(4'h6, 0, 64'd0, 64'd2, 64'd0, 2, 0, 3'b000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
